// File: rtl/error_pkg.sv
// Shared types and default sizes for the error reporting path downstream of error_d8.
package error_pkg;
    localparam int H_DEF  = 8;
    localparam int CW_DEF = 8;

    typedef enum logic {SEV_WARN = 1'b0, SEV_ERR = 1'b1} sev_t;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} rep_state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin finder: first set request at or after start, wrapping.
module rr_pick8
    import error_pkg::*;
#(
    parameter int H = H_DEF,
    localparam int CHW = $clog2(H)
) (
    input  logic [H-1:0]   req,
    input  logic [CHW-1:0] start,
    output logic           found,
    output logic [CHW-1:0] index
);
    logic [CHW-1:0] cand;

    // Scan from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = H - 1; k >= 0; k--) begin
            cand = CHW'((int'(start) + k) % H);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end
endmodule

// File: rtl/error_reporter8.sv
// Captures warning/error rises into sticky pending bits and reports them one record
// at a time over valid/ready, errors first, round-robin across channels.
module error_reporter8
    import error_pkg::*;
#(
    parameter int H  = H_DEF,
    parameter int CW = CW_DEF,
    localparam int CHW = $clog2(H)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [H-1:0]   warning,
    input  logic [H-1:0]   error,
    input  logic           clear,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [CHW-1:0] ev_chan,
    output logic           ev_sev,
    output logic [CW-1:0]  ev_count,
    output logic           alarm
);
    logic [H-1:0]   prev_w, prev_e;
    logic [H-1:0]   warn_pend, err_pend;
    logic [CW-1:0]  cnt [H];
    logic [CHW-1:0] rr_ptr;
    rep_state_t     state;

    logic [H-1:0]   rise_w, rise_e, hs_mask;
    logic           handshake;
    logic           err_found, warn_found;
    logic [CHW-1:0] err_idx, warn_idx, pick_idx, next_ptr;

    assign rise_w    = warning & ~prev_w;
    assign rise_e    = error & ~prev_e;
    assign handshake = ev_valid & ev_ready;
    assign hs_mask   = handshake ? (H'(1) << ev_chan) : '0;
    assign pick_idx  = err_found ? err_idx : warn_idx;
    assign next_ptr  = (ev_chan == CHW'(H - 1)) ? '0 : ev_chan + CHW'(1);

    rr_pick8 #(.H(H)) u_pick_err (
        .req   (err_pend),
        .start (rr_ptr),
        .found (err_found),
        .index (err_idx)
    );

    rr_pick8 #(.H(H)) u_pick_warn (
        .req   (warn_pend),
        .start (rr_ptr),
        .found (warn_found),
        .index (warn_idx)
    );

    // A rise in the same cycle as the handshake clear keeps the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_w    <= '0;
            prev_e    <= '0;
            warn_pend <= '0;
            err_pend  <= '0;
            for (int i = 0; i < H; i++) cnt[i] <= '0;
        end else begin
            prev_w <= warning;
            prev_e <= error;
            if (clear) begin
                warn_pend <= '0;
                err_pend  <= '0;
                for (int i = 0; i < H; i++) cnt[i] <= '0;
            end else begin
                err_pend  <= (err_pend  & ~(ev_sev ? hs_mask : '0)) | rise_e;
                warn_pend <= (warn_pend & ~(ev_sev ? '0 : hs_mask)) | rise_w;
                for (int i = 0; i < H; i++) begin
                    if (rise_e[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // The record is frozen for the whole SEND state, even across a clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_chan  <= '0;
            ev_sev   <= 1'b0;
            ev_count <= '0;
            rr_ptr   <= '0;
            alarm    <= 1'b0;
        end else begin
            alarm <= (|err_pend) | (ev_valid & ev_sev);
            case (state)
                IDLE: begin
                    if (err_found || warn_found) begin
                        ev_valid <= 1'b1;
                        ev_chan  <= pick_idx;
                        ev_sev   <= err_found ? SEV_ERR : SEV_WARN;
                        ev_count <= cnt[pick_idx];
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
